masked_write_arb: RTL and testbench
===================================

# masked_write_arb

Shared-register write arbiter: up to NREQ requesters issue masked (bit-field) writes to one WIDTH-bit register, granted one per cycle round-robin, with optional multi-cycle ownership locks and a lock timeout. Partial writes merge as `q = (q & ~mask) | (data & mask)`, so disjoint fields written on different cycles accumulate. It sits between control agents and a shared mode/config register in the test datapath.

## Interface
- NREQ, 4, number of requesters (2..8)
- WIDTH, 16, register width
- RESET_VAL, 0, value of reg_q after reset
- LOCK_MAX, 8, max cycles a lock may be held without a transfer by its owner (≥1)

- clk  input  1  rising-edge clock; the only clock
- rst_n  input  1  reset, asynchronous assert, active-low
- req_valid  input  NREQ  per-requester write request
- req_lock  input  NREQ  request to hold ownership after this transfer
- req_data  input  NREQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
- req_mask  input  NREQ*WIDTH  bit-enable mask, same packing
- req_ready  output  NREQ  one-hot-or-zero grant, combinational
- reg_q  output  WIDTH  shared register
- grant_id  output  3  index of last granted requester, registered
- wr_count  output  16  number of completed transfers, wraps
- locked  output  1  high while in LOCKED state
- lock_timeout  output  1  one-cycle pulse on forced lock release

## Operation
- Transfer on requester i when req_valid[i] & req_ready[i].
- States: IDLE, LOCKED(owner).
- IDLE: grant highest-priority valid requester; priority starts at (rr_ptr) and proceeds upward modulo NREQ. After a transfer from i, rr_ptr = (i+1) mod NREQ. No valid -> no grant, rr_ptr unchanged.
- Transfer with req_lock[i]=1 in IDLE -> LOCKED(owner=i), lock counter cleared.
- LOCKED: req_ready = owner bit only if req_valid[owner]; all others 0.
  - owner transfer with lock=1: stay, counter cleared.
  - owner transfer with lock=0: -> IDLE, rr_ptr = owner+1.
  - no owner transfer: counter increments; reaching LOCK_MAX -> IDLE, lock_timeout pulses, rr_ptr = owner+1.
- Write merge: reg_q <= (reg_q & ~mask) | (data & mask) of the granted requester. Mask of all zeros still counts as a transfer (wr_count increments, reg_q unchanged).
- wr_count: +1 per transfer, 16-bit wraparound 0xFFFF -> 0.
- Reset (any time, including mid-lock): reg_q=RESET_VAL, grant_id=0, wr_count=0, locked=0, lock_timeout=0, state IDLE, rr_ptr=0, lock counter=0; req_ready=0 while rst_n low.

## Timing
- req_ready combinational from req_valid, state, rr_ptr (same cycle).
- reg_q, grant_id, wr_count update at the edge ending the transfer cycle (visible next cycle).
- Exactly one transfer per cycle maximum; losers hold valid/data/mask stable until granted.
- locked rises the cycle after the locking transfer; falls the cycle after release/timeout; lock_timeout is high in that same cycle.
- Timeout and an owner transfer in the same cycle: transfer wins, no timeout.

## Configuration
- MASKED_WRITE_ARB_HISTORY_EN defined: adds outputs grant_d1, grant_d2, grant_d3 (3 bits each), a three-stage shift of grant_id, reset to 0, advancing every cycle regardless of transfers.
- Undefined: those ports and registers absent; all other behaviour identical.

## Test plan
- Reset, then requester 0 writes data 0x6000 mask 0x6000, next cycle requester 2 writes 0x1000 mask 0x1000, then requester 1 writes 0x0800 mask 0x0C00, then requester 3 writes 0x0000 mask 0x2000 -> reg_q reads 0x7000, then 0x7800, then 0x5800; wr_count=4.
- All four valid continuously for 8 cycles -> grant order 0,1,2,3,0,1,2,3; grant_id follows one cycle later.
- Requester 1 transfers with lock=1 while 0,2,3 valid; owner sends 2 more locked writes then lock=0 -> only 1 granted for 3 transfers, then requester 2 granted next.
- LOCK_MAX=8, requester 3 locks then drops valid -> no grants for 8 cycles, lock_timeout pulses once, locked falls, requester 0 granted next cycle.
- rst_n asserted during LOCKED with reg_q=0xABCD -> reg_q=RESET_VAL, locked=0, wr_count=0 immediately; after release requester 0 wins.
- With MASKED_WRITE_ARB_HISTORY_EN: grants 1,2,3 in consecutive cycles -> grant_d3 shows 1 three cycles after grant_id shows 1; wr_count preset near 0xFFFF by 65535 transfers wraps to 0.

Source files
------------

// File: rtl/masked_write_arb_if.sv
// Request bus between write agents and the shared-register arbiter.
interface masked_write_arb_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 16
);
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_lock;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ*WIDTH-1:0] req_mask;
    logic [NREQ-1:0]       req_ready;

    modport master (
        output req_valid, req_lock, req_data, req_mask,
        input  req_ready
    );

    modport slave (
        input  req_valid, req_lock, req_data, req_mask,
        output req_ready
    );
endinterface

// File: rtl/masked_write_arb.sv
// Round-robin masked-write arbiter onto one shared register, with ownership locks, lock timeout and optional grant history (MASKED_WRITE_ARB_HISTORY_EN).
// Latency: req_ready is combinational; reg_q/grant_id/wr_count update at the edge ending the transfer cycle.
// Backpressure: at most one grant per cycle; losers and non-owners see req_ready low and must hold their request.
module masked_write_arb #(
    parameter int               NREQ      = 4,
    parameter int               WIDTH     = 16,
    parameter logic [WIDTH-1:0] RESET_VAL = '0,
    parameter int               LOCK_MAX  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    masked_write_arb_if.slave bus,
    output logic [WIDTH-1:0]  reg_q,
    output logic [2:0]        grant_id,
    output logic [15:0]       wr_count,
    output logic              locked,
    output logic              lock_timeout
`ifdef MASKED_WRITE_ARB_HISTORY_EN
   ,output logic [2:0]        grant_d1,
    output logic [2:0]        grant_d2,
    output logic [2:0]        grant_d3
`endif
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(LOCK_MAX + 1);

    typedef enum logic {S_IDLE, S_LOCKED} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     rr_ptr, rr_ptr_n;
    logic [PW-1:0]     owner, owner_n;
    logic [CW-1:0]     lock_cnt, lock_cnt_n;
    logic [WIDTH-1:0]  reg_q_n;
    logic [2:0]        grant_id_n;
    logic [15:0]       wr_count_n;
    logic              lock_timeout_n;

    logic [NREQ-1:0]   ready;
    logic              pick_vld;
    logic [PW-1:0]     pick_idx;
    logic              xfer;
    logic [PW-1:0]     xidx;
    logic [WIDTH-1:0]  xdata, xmask;
    int                idx_int;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (int'(p) == NREQ - 1) ? '0 : p + PW'(1);
    endfunction

    // First valid requester at or above rr_ptr, wrapping modulo NREQ.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        idx_int  = 0;
        for (int k = 0; k < NREQ; k++) begin
            idx_int = int'(rr_ptr) + k;
            if (idx_int >= NREQ) idx_int = idx_int - NREQ;
            if (!pick_vld && bus.req_valid[idx_int]) begin
                pick_vld = 1'b1;
                pick_idx = PW'(idx_int);
            end
        end
    end

    always_comb begin
        state_n        = state;
        rr_ptr_n       = rr_ptr;
        owner_n        = owner;
        lock_cnt_n     = lock_cnt;
        reg_q_n        = reg_q;
        grant_id_n     = grant_id;
        wr_count_n     = wr_count;
        lock_timeout_n = 1'b0;
        ready          = '0;
        xfer           = 1'b0;
        xidx           = '0;

        case (state)
            S_IDLE: begin
                if (pick_vld) begin
                    xfer = 1'b1;
                    xidx = pick_idx;
                end
            end
            S_LOCKED: begin
                if (bus.req_valid[owner]) begin
                    xfer = 1'b1;
                    xidx = owner;
                end
            end
            default: state_n = S_IDLE;
        endcase

        if (!rst_n) xfer = 1'b0;
        if (xfer) ready[xidx] = 1'b1;

        xdata = bus.req_data[int'(xidx)*WIDTH +: WIDTH];
        xmask = bus.req_mask[int'(xidx)*WIDTH +: WIDTH];

        if (xfer) begin
            reg_q_n    = (reg_q & ~xmask) | (xdata & xmask);
            grant_id_n = 3'(xidx);
            wr_count_n = wr_count + 16'd1;
            rr_ptr_n   = inc_ptr(xidx);
            lock_cnt_n = '0;
            owner_n    = xidx;
            state_n    = bus.req_lock[xidx] ? S_LOCKED : S_IDLE;
        end else if (state == S_LOCKED) begin
            // An owner transfer in the same cycle pre-empts this branch, so transfer beats timeout.
            if (lock_cnt + CW'(1) == CW'(LOCK_MAX)) begin
                state_n        = S_IDLE;
                lock_timeout_n = 1'b1;
                rr_ptr_n       = inc_ptr(owner);
                lock_cnt_n     = '0;
            end else begin
                lock_cnt_n = lock_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            owner        <= '0;
            lock_cnt     <= '0;
            reg_q        <= RESET_VAL;
            grant_id     <= '0;
            wr_count     <= '0;
            lock_timeout <= 1'b0;
        end else begin
            state        <= state_n;
            rr_ptr       <= rr_ptr_n;
            owner        <= owner_n;
            lock_cnt     <= lock_cnt_n;
            reg_q        <= reg_q_n;
            grant_id     <= grant_id_n;
            wr_count     <= wr_count_n;
            lock_timeout <= lock_timeout_n;
        end
    end

    assign bus.req_ready = ready;
    assign locked        = (state == S_LOCKED);

`ifdef MASKED_WRITE_ARB_HISTORY_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_d1 <= '0;
            grant_d2 <= '0;
            grant_d3 <= '0;
        end else begin
            grant_d1 <= grant_id;
            grant_d2 <= grant_d1;
            grant_d3 <= grant_d2;
        end
    end
`endif

endmodule

// File: tb/tb_masked_write_arb.sv
// Bench for masked_write_arb: fixed vectors, directed lock/timeout/reset/wrap sequences, random traffic against a reference model.
module tb_masked_write_arb;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int LM = 8;
    localparam logic [W-1:0] RV = 16'h0000;

    logic clk;
    logic rst_n;
    logic [W-1:0]  reg_q;
    logic [2:0]    grant_id;
    logic [15:0]   wr_count;
    logic          locked;
    logic          lock_timeout;
`ifdef MASKED_WRITE_ARB_HISTORY_EN
    logic [2:0]    grant_d1, grant_d2, grant_d3;
`endif

    masked_write_arb_if #(.NREQ(N), .WIDTH(W)) bus ();

    masked_write_arb #(.NREQ(N), .WIDTH(W), .RESET_VAL(RV), .LOCK_MAX(LM)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .reg_q        (reg_q),
        .grant_id     (grant_id),
        .wr_count     (wr_count),
        .locked       (locked),
        .lock_timeout (lock_timeout)
`ifdef MASKED_WRITE_ARB_HISTORY_EN
       ,.grant_d1     (grant_d1),
        .grant_d2     (grant_d2),
        .grant_d3     (grant_d3)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference state, kept as plain integers and flags.
    logic [W-1:0] m_q;
    logic [15:0]  m_cnt;
    int           m_gid, m_rr, m_owner, m_age;
    bit           m_locked, m_to;
    int           m_hist[3];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q = RV; m_cnt = 16'd0; m_gid = 0; m_rr = 0; m_owner = 0; m_age = 0;
        m_locked = 1'b0; m_to = 1'b0;
        for (int i = 0; i < 3; i++) m_hist[i] = 0;
    endtask

    function automatic logic [N-1:0] model_ready();
        logic [N-1:0] r;
        int i;
        r = '0;
        if (!rst_n) return r;
        if (m_locked) begin
            if (bus.req_valid[m_owner]) r[m_owner] = 1'b1;
        end else begin
            for (int k = 0; k < N; k++) begin
                i = (m_rr + k) % N;
                if (bus.req_valid[i]) begin
                    r[i] = 1'b1;
                    break;
                end
            end
        end
        return r;
    endfunction

    task automatic model_step(input logic [N-1:0] g);
        int win;
        logic [W-1:0] d, mk;
        win = -1;
        for (int i = 0; i < N; i++) if (g[i]) win = i;
        m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = m_gid;
        m_to = 1'b0;
        if (win >= 0) begin
            d  = bus.req_data[win*W +: W];
            mk = bus.req_mask[win*W +: W];
            m_q   = (m_q & ~mk) | (d & mk);
            m_cnt = m_cnt + 16'd1;
            m_gid = win;
            m_rr  = (win + 1) % N;
            m_age = 0;
            if (bus.req_lock[win]) begin
                m_locked = 1'b1;
                m_owner  = win;
            end else begin
                m_locked = 1'b0;
            end
        end else if (m_locked) begin
            m_age++;
            if (m_age == LM) begin
                m_locked = 1'b0;
                m_to     = 1'b1;
                m_rr     = (m_owner + 1) % N;
                m_age    = 0;
            end
        end
    endtask

    // One clock: ready compared mid-cycle, registered outputs just after the edge.
    task automatic tick(output logic [N-1:0] rdy);
        logic [N-1:0] exp_r;
        @(negedge clk);
        exp_r = model_ready();
        rdy   = bus.req_ready;
        check("ready", 32'(rdy), 32'(exp_r));
        model_step(exp_r);
        @(posedge clk); #1;
        check("reg_q", 32'(reg_q), 32'(m_q));
        check("grant_id", 32'(grant_id), 32'(m_gid));
        check("wr_count", 32'(wr_count), 32'(m_cnt));
        check("locked", 32'(locked), 32'(m_locked));
        check("lock_timeout", 32'(lock_timeout), 32'(m_to));
`ifdef MASKED_WRITE_ARB_HISTORY_EN
        check("grant_d1", 32'(grant_d1), 32'(m_hist[0]));
        check("grant_d2", 32'(grant_d2), 32'(m_hist[1]));
        check("grant_d3", 32'(grant_d3), 32'(m_hist[2]));
`endif
    endtask

    task automatic clear_inputs();
        bus.req_valid = '0; bus.req_lock = '0; bus.req_data = '0; bus.req_mask = '0;
    endtask

    task automatic set_all(input logic [N-1:0] v, input logic [N-1:0] l,
                           input logic [W-1:0] d, input logic [W-1:0] mk);
        bus.req_valid = v;
        bus.req_lock  = l;
        for (int i = 0; i < N; i++) begin
            bus.req_data[i*W +: W] = d;
            bus.req_mask[i*W +: W] = mk;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_inputs();
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_reg_q", 32'(reg_q), 32'(RV));
        check("rst_grant_id", 32'(grant_id), 32'(0));
        check("rst_wr_count", 32'(wr_count), 32'(0));
        check("rst_locked", 32'(locked), 32'(0));
        check("rst_lock_timeout", 32'(lock_timeout), 32'(0));
    endtask

    typedef struct {
        logic [N-1:0] valid;
        logic [W-1:0] data;
        logic [W-1:0] mask;
        logic [N-1:0] exp_ready;
        logic [W-1:0] exp_q;
        logic [15:0]  exp_cnt;
    } vec_t;

    vec_t vec[10];

    initial begin
        logic [N-1:0] rdy;
        int pulses;

        vec[0] = '{4'b0001, 16'h6000, 16'h6000, 4'b0001, 16'h6000, 16'd1};
        vec[1] = '{4'b0100, 16'h1000, 16'h1000, 4'b0100, 16'h7000, 16'd2};
        vec[2] = '{4'b0010, 16'h0800, 16'h0C00, 4'b0010, 16'h7800, 16'd3};
        vec[3] = '{4'b1000, 16'h0000, 16'h2000, 4'b1000, 16'h5800, 16'd4};
        vec[4] = '{4'b0000, 16'hFFFF, 16'hFFFF, 4'b0000, 16'h5800, 16'd4};
        vec[5] = '{4'b1111, 16'hFFFF, 16'h0000, 4'b0001, 16'h5800, 16'd5};
        vec[6] = '{4'b1111, 16'h00FF, 16'h00FF, 4'b0010, 16'h58FF, 16'd6};
        vec[7] = '{4'b1001, 16'h0000, 16'hFFFF, 4'b1000, 16'h0000, 16'd7};
        vec[8] = '{4'b1010, 16'h1234, 16'hFFFF, 4'b0010, 16'h1234, 16'd8};
        vec[9] = '{4'b0011, 16'hAAAA, 16'hF0F0, 4'b0001, 16'hA2A4, 16'd9};

        rst_n = 1'b0;
        clear_inputs();
        do_reset();

        // Fixed vectors: field merges and rotating priority.
        for (int v = 0; v < 10; v++) begin
            set_all(vec[v].valid, '0, vec[v].data, vec[v].mask);
            tick(rdy);
            check($sformatf("vec%0d_ready", v), 32'(rdy), 32'(vec[v].exp_ready));
            check($sformatf("vec%0d_q", v), 32'(reg_q), 32'(vec[v].exp_q));
            check($sformatf("vec%0d_cnt", v), 32'(wr_count), 32'(vec[v].exp_cnt));
        end

        // All four contending: strict rotation, grant_id one cycle behind.
        do_reset();
        set_all(4'b1111, '0, 16'h0000, 16'h0000);
        for (int k = 0; k < 8; k++) begin
            tick(rdy);
            check("rr_order", 32'(rdy), 32'(1 << (k % 4)));
            check("rr_grant_id", 32'(grant_id), 32'(k % 4));
        end

        // Requester 1 locks and keeps ownership for three transfers.
        do_reset();
        set_all(4'b0001, '0, 16'h0001, 16'h0001);
        tick(rdy);
        set_all(4'b1111, 4'b0010, 16'h0F0F, 16'h00FF);
        for (int k = 0; k < 3; k++) begin
            if (k == 2) bus.req_lock = '0;
            tick(rdy);
            check("lock_owner_only", 32'(rdy), 32'(4'b0010));
        end
        tick(rdy);
        check("lock_release_next", 32'(rdy), 32'(4'b0100));

        // Requester 3 locks then goes quiet until the timeout fires.
        do_reset();
        set_all(4'b1000, 4'b1000, 16'h1111, 16'hFFFF);
        tick(rdy);
        check("to_lock_grant", 32'(rdy), 32'(4'b1000));
        check("to_locked", 32'(locked), 32'(1));
        set_all(4'b0001, '0, 16'h2222, 16'hFFFF);
        pulses = 0;
        for (int k = 0; k < LM; k++) begin
            tick(rdy);
            check("to_no_grant", 32'(rdy), 32'(0));
            if (lock_timeout) pulses++;
        end
        check("to_locked_fall", 32'(locked), 32'(0));
        check("to_pulse_now", 32'(lock_timeout), 32'(1));
        tick(rdy);
        if (lock_timeout) pulses++;
        check("to_next_grant", 32'(rdy), 32'(4'b0001));
        check("to_pulse_count", 32'(pulses), 32'(1));

        // Asynchronous reset while locked.
        do_reset();
        set_all(4'b0100, 4'b0100, 16'hABCD, 16'hFFFF);
        tick(rdy);
        check("rl_q", 32'(reg_q), 32'(16'hABCD));
        check("rl_locked", 32'(locked), 32'(1));
        set_all(4'b0111, '0, 16'h0000, 16'h0000);
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rl_q_async", 32'(reg_q), 32'(RV));
        check("rl_locked_async", 32'(locked), 32'(0));
        check("rl_cnt_async", 32'(wr_count), 32'(0));
        check("rl_ready_async", 32'(bus.req_ready), 32'(0));
        #2;
        rst_n = 1'b1;
        tick(rdy);
        check("rl_first_winner", 32'(rdy), 32'(4'b0001));

        // wr_count wraps after 65536 transfers.
        do_reset();
        set_all(4'b0001, '0, 16'h0000, 16'h0000);
        repeat (65535) @(posedge clk);
        #1;
        check("wrap_ffff", 32'(wr_count), 32'(16'hFFFF));
        @(posedge clk); #1;
        check("wrap_zero", 32'(wr_count), 32'(0));
        clear_inputs();

        // Random traffic; a requester holds its request until granted.
        do_reset();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
                    bus.req_valid[i]       = 1'b1;
                    bus.req_lock[i]        = ($urandom_range(0, 5) == 0);
                    bus.req_data[i*W +: W] = 16'($urandom);
                    bus.req_mask[i*W +: W] = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
                end
            end
            tick(rdy);
            for (int i = 0; i < N; i++) begin
                if (rdy[i]) begin
                    bus.req_valid[i]       = ($urandom_range(0, 1) == 1);
                    bus.req_lock[i]        = ($urandom_range(0, 3) == 0);
                    bus.req_data[i*W +: W] = 16'($urandom);
                    bus.req_mask[i*W +: W] = 16'($urandom);
                end
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
